// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared SM3 digest-output types and constants
package sm3_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dgst_state_e;

    localparam int SM3_DGST_W    = 256;
    localparam int OTPT_DW_LEGAL_0 = 32;
    localparam int OTPT_DW_LEGAL_1 = 64;

    function automatic bit otpt_dw_legal(input int dw);
        return (dw == OTPT_DW_LEGAL_0) || (dw == OTPT_DW_LEGAL_1);
    endfunction

endpackage

// File: rtl/sm3_dgst_otpt.sv
// rtl/sm3_dgst_otpt.sv - serialises 256-bit SM3 digests into OTPT_DW-wide words
module sm3_dgst_otpt
    import sm3_pkg::*;
#(
    parameter int OTPT_DW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [255:0]       cmprss_inpt_res_i,
    input  logic               cmprss_inpt_vld_i,
    output logic [OTPT_DW-1:0] dgst_otpt_d_o,
    output logic               dgst_otpt_vld_o,
    output logic               dgst_otpt_lst_o,
    input  logic               dgst_otpt_rdy_i,
    output logic               dgst_busy_o,
    output logic               dgst_ovf_o,
    input  logic               dgst_ovf_clr_i
);

    localparam int WORD_NUM = SM3_DGST_W / OTPT_DW;
    localparam int CW       = $clog2(WORD_NUM);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD_NUM - 1);

    if (!otpt_dw_legal(OTPT_DW)) begin : g_bad_otpt_dw
        $error("sm3_dgst_otpt: OTPT_DW must be 32 or 64");
    end

    dgst_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [255:0]      act_q, act_d;
    logic [255:0]      pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              ovf_q, ovf_d;

    logic xfer;
    logic last_xfer;

    assign xfer      = (state_q == SEND) && dgst_otpt_rdy_i;
    assign last_xfer = xfer && (cnt_q == CNT_LAST);

    // ACTIVE is shifted left per transfer so the current word is always the top slice.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovf_d      = ovf_q;

        if (dgst_ovf_clr_i) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmprss_inpt_vld_i) begin
                    act_d   = cmprss_inpt_res_i;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    cnt_d = '0;
                    if (pend_vld_q) begin
                        act_d      = pend_q;
                        pend_vld_d = cmprss_inpt_vld_i;
                        if (cmprss_inpt_vld_i) begin
                            pend_d = cmprss_inpt_res_i;
                        end
                    end else if (cmprss_inpt_vld_i) begin
                        act_d = cmprss_inpt_res_i;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        act_d = act_q << OTPT_DW;
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cmprss_inpt_vld_i) begin
                        if (!pend_vld_q) begin
                            pend_d     = cmprss_inpt_res_i;
                            pend_vld_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign dgst_otpt_d_o   = act_q[255 -: OTPT_DW];
    assign dgst_otpt_vld_o = (state_q == SEND);
    assign dgst_otpt_lst_o = (state_q == SEND) && (cnt_q == CNT_LAST);
    assign dgst_busy_o     = (state_q == SEND) || pend_vld_q;
    assign dgst_ovf_o      = ovf_q;

endmodule

// File: doc/sm3_dgst_otpt.md
SM3_DGST_OTPT -- requirements
Module: sm3_dgst_otpt

Interface
REQ-001 SHALL have parameter OTPT_DW, default 32, output word width; legal values are 32 and 64 only.
REQ-002 SHALL have derived constant WORD_NUM = 256/OTPT_DW, default 8, words per digest.
REQ-003 clk  input  1  sole clock; all state on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 cmprss_inpt_res_i  input  256  digest from the SM3 compression stage.
REQ-006 cmprss_inpt_vld_i  input  1  single-cycle strobe; digest is valid this cycle.
REQ-007 dgst_otpt_d_o  output  OTPT_DW  current digest word.
REQ-008 dgst_otpt_vld_o  output  1  dgst_otpt_d_o is valid.
REQ-009 dgst_otpt_lst_o  output  1  current word is the last word of its digest.
REQ-010 dgst_otpt_rdy_i  input  1  consumer accepts the word when it is high together with vld.
REQ-011 dgst_busy_o  output  1  active or pending digest held.
REQ-012 dgst_ovf_o  output  1  sticky flag; a digest was dropped.
REQ-013 dgst_ovf_clr_i  input  1  clears dgst_ovf_o.

Function
REQ-014 SHALL hold two digest buffers: ACTIVE, which is being serialised, and PEND, a one-deep holding register with its own valid bit.
REQ-015 SHALL use state machine IDLE/SEND; SEND is equivalent to "ACTIVE valid".
REQ-016 IDLE with cmprss_inpt_vld_i: load ACTIVE, clear the word counter, enter SEND; dgst_otpt_vld_o SHALL be high on the next cycle (latency 1).
REQ-017 SHALL output the most-significant word first: word k = res[255-k*OTPT_DW -: OTPT_DW], k = 0..WORD_NUM-1.
REQ-018 A word SHALL transfer only on vld&rdy; the counter advances by 1 per transfer.
REQ-019 Without a transfer, dgst_otpt_d_o and dgst_otpt_lst_o SHALL be held stable.
REQ-020 dgst_otpt_vld_o SHALL NOT drop until the last word has transferred.
REQ-021 dgst_otpt_lst_o SHALL be high exactly when counter = WORD_NUM-1 in SEND.
REQ-022 On the last-word transfer, if PEND is valid: move PEND to ACTIVE, clear PEND valid, reset the counter, and stay in SEND with no bubble cycle.
REQ-023 On the last-word transfer, if PEND is empty and cmprss_inpt_vld_i is high: load the input straight into ACTIVE and stay in SEND.
REQ-024 On the last-word transfer, if PEND is empty and no input arrives: return to IDLE.
REQ-025 In SEND with no last-word transfer, an input SHALL go to PEND if PEND is empty.
REQ-026 In SEND with no last-word transfer and PEND full, the input SHALL be dropped: PEND unchanged, dgst_ovf_o set next cycle.
REQ-027 If an input coincides with a last-word transfer while PEND is full, PEND SHALL move to ACTIVE and the input SHALL move to PEND; no overflow.
REQ-028 dgst_ovf_clr_i SHALL clear dgst_ovf_o next cycle; if set and clear occur in the same cycle, set SHALL win.
REQ-029 dgst_busy_o = SEND | PEND valid, combinational from registers.
REQ-030 All outputs SHALL be driven from registers or from decode of registers only; no combinational path from rdy_i to any output.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, counter 0, PEND valid 0, dgst_otpt_vld_o 0, dgst_otpt_lst_o 0, dgst_busy_o 0, dgst_ovf_o 0.
REQ-032 Reset SHALL force dgst_otpt_d_o to 0 and clear the ACTIVE and PEND data.
REQ-033 Reset mid-digest SHALL discard all held digests; no partial word is emitted after release.
REQ-034 First capture SHALL be possible on the first clock edge after rst_n deasserts.

Structure
REQ-035 Shared package sm3_pkg SHALL hold: the state enum (IDLE, SEND), constant SM3_DGST_W = 256, and legal OTPT_DW values.
REQ-036 The module SHALL be flat with no sub-module; the two buffers plus the serialiser are the whole block.
REQ-037 The module SHALL elaborate-time assert OTPT_DW in {32, 64}.

Verification
REQ-038 Single digest, rdy=1, digest = 66c7f0f4...8f4ba8e0 (SM3 "abc"): 8 words starting 32'h66c7f0f4 on consecutive cycles, lst on the 8th, vld low afterwards.
REQ-039 Back-pressure: rdy toggles 1,0,0,1,... -> each word held stable while rdy=0; word order unchanged; exactly 8 transfers.
REQ-040 Two digests A and B, 3 cycles apart, rdy=1 -> 16 contiguous words, A then B, no bubble, ovf=0.
REQ-041 Three digests during a stalled first send (rdy=0) -> A and B delivered, C dropped, ovf=1 until clr pulse, then 0.
REQ-042 Input coinciding with A's last-word transfer while B is in PEND -> order A, B, C; ovf=0.
REQ-043 rst_n low at word 3 of A -> vld=0 immediately, busy=0, no A words emitted after release; OTPT_DW=64 rerun of the "abc" case yields 4 words, first 64'h66c7f0f4_62eeedd9.
